pair_step_checker: RTL

//  Downstream consumer of the X/Y counter pair. Samples (X,Y) once per producer step.

---
 rtl/pair_step_checker_pkg.sv | 23 ++
 rtl/pair_step_checker_if.sv | 27 ++
 rtl/pair_step_checker_next.sv | 30 +++
 rtl/pair_step_checker.sv | 93 +++++++++
 4 files changed

// File: rtl/pair_step_checker_pkg.sv
// Shared types and constants for the X/Y pair step checker.
// The checker FSM states and the fault-code encodings live here.
package pair_chk_pkg;

    localparam int DEF_W     = 400;
    localparam int DEF_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    // Fault code bit 1 = step mismatch, bit 0 = ordering (Y > X).
    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_ORDER = 2'b01;
    localparam logic [1:0] FC_STEP  = 2'b10;
    localparam logic [1:0] FC_BOTH  = 2'b11;

    // CNT_MAX is the all-ones value of the pair width.
    localparam logic [DEF_W-1:0] DEF_CNT_MAX = {DEF_W{1'b1}};

endpackage

// File: rtl/pair_step_checker_if.sv
// Sample/clear inputs and fault-record outputs of the pair step checker.
// The producer side drives through master; the checker uses slave.
interface pair_step_checker_if #(
    parameter int W     = 400,
    parameter int CNT_W = 32
);
    logic             pair_valid;
    logic [W-1:0]     x_in;
    logic [W-1:0]     y_in;
    logic             clr;
    logic             fault;
    logic [1:0]       fault_code;
    logic [W-1:0]     bad_x;
    logic [W-1:0]     bad_y;
    logic [CNT_W-1:0] step_cnt;
    logic             synced;

    modport master (
        output pair_valid, x_in, y_in, clr,
        input  fault, fault_code, bad_x, bad_y, step_cnt, synced
    );

    modport slave (
        input  pair_valid, x_in, y_in, clr,
        output fault, fault_code, bad_x, bad_y, step_cnt, synced
    );
endinterface

// File: rtl/pair_step_checker_next.sv
// Combinational next-pair function f(X,Y) of the X/Y counter producer.
// Shared by the producer and the checker so both use one definition.
module cnt_pair_next #(
    parameter int W = 400
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o
);
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    always_comb begin
        x_o = x_i;
        y_o = y_i;
        if (y_i == x_i) begin
            // Both wrap to zero together at CNT_MAX.
            x_o = x_i + W'(1);
            y_o = y_i + W'(1);
        end else if (y_i > x_i) begin
            x_o = x_i;
            y_o = y_i;
        end else if (x_i != CNT_MAX) begin
            x_o = x_i + W'(1);
        end else begin
            x_o = y_i;
            y_o = x_i;
        end
    end
endmodule

// File: rtl/pair_step_checker.sv
// Checks each accepted (X,Y) sample against f(previous pair) and the Y<=X
// ordering, keeping a sticky record of the first violation.
module pair_step_checker
    import pair_chk_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    pair_step_checker_if.slave  bus_if
);
    state_e           state_q;
    logic [W-1:0]     prev_x_q;
    logic [W-1:0]     prev_y_q;
    logic [W-1:0]     bad_x_q;
    logic [W-1:0]     bad_y_q;
    logic             fault_q;
    logic             synced_q;
    logic [1:0]       code_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [W-1:0]     exp_x;
    logic [W-1:0]     exp_y;
    logic             order_err;
    logic             step_err;

    cnt_pair_next #(.W(W)) u_next (
        .x_i (prev_x_q),
        .y_i (prev_y_q),
        .x_o (exp_x),
        .y_o (exp_y)
    );

    assign order_err = (bus_if.y_in > bus_if.x_in);
    assign step_err  = (bus_if.x_in != exp_x) || (bus_if.y_in != exp_y);
    assign cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst || bus_if.clr) begin
            // A clear drops any same-cycle sample instead of seeding with it.
            state_q  <= IDLE;
            prev_x_q <= '0;
            prev_y_q <= '0;
            bad_x_q  <= '0;
            bad_y_q  <= '0;
            fault_q  <= 1'b0;
            synced_q <= 1'b0;
            code_q   <= FC_NONE;
            cnt_q    <= '0;
        end else if (bus_if.pair_valid) begin
            case (state_q)
                IDLE: begin
                    prev_x_q <= bus_if.x_in;
                    prev_y_q <= bus_if.y_in;
                    synced_q <= 1'b1;
                    if (order_err) begin
                        fault_q <= 1'b1;
                        code_q  <= FC_ORDER;
                        bad_x_q <= bus_if.x_in;
                        bad_y_q <= bus_if.y_in;
                        state_q <= FAULT;
                    end else begin
                        state_q <= TRACK;
                    end
                end
                TRACK: begin
                    if (order_err || step_err) begin
                        fault_q <= 1'b1;
                        code_q  <= {step_err, order_err};
                        bad_x_q <= bus_if.x_in;
                        bad_y_q <= bus_if.y_in;
                        state_q <= FAULT;
                    end else begin
                        prev_x_q <= bus_if.x_in;
                        prev_y_q <= bus_if.y_in;
                        cnt_q    <= cnt_d;
                    end
                end
                default: begin
                    state_q <= FAULT;
                end
            endcase
        end
    end

    assign bus_if.fault      = fault_q;
    assign bus_if.fault_code = code_q;
    assign bus_if.bad_x      = bad_x_q;
    assign bus_if.bad_y      = bad_y_q;
    assign bus_if.step_cnt   = cnt_q;
    assign bus_if.synced     = synced_q;
endmodule
